// File: rtl/alu_issue_scheduler_if.sv
// Dispatch, wakeup and issue-side signal bundle for the ALU issue scheduler.
// The scheduler binds to the slave modport; the driving environment uses master.
interface alu_issue_scheduler_if #(
  parameter int DEPTH              = 4,
  parameter int XLEN               = 64,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int ROB_INDEX_WIDTH    = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                          enq_valid_i;
  logic                          enq_ready_o;
  logic [2:0]                    enq_func_i;
  logic                          enq_mod_i;
  logic                          enq_half_i;
  logic                          enq_rs1_ready_i;
  logic                          enq_rs2_ready_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] enq_rs1_tag_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] enq_rs2_tag_i;
  logic [XLEN-1:0]               enq_rs1_data_i;
  logic [XLEN-1:0]               enq_rs2_data_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] enq_rd_i;
  logic [ROB_INDEX_WIDTH-1:0]    enq_rob_i;

  logic                          wb_valid_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb_tag_i;
  logic [XLEN-1:0]               wb_data_i;

  logic                          alu_ready_i;
  logic                          issue_valid_o;
  logic [XLEN-1:0]               issue_a_o;
  logic [XLEN-1:0]               issue_b_o;
  logic [2:0]                    issue_func_o;
  logic                          issue_mod_o;
  logic                          issue_half_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] issue_rd_o;
  logic [ROB_INDEX_WIDTH-1:0]    issue_rob_o;
  logic [CW-1:0]                 count_o;

  modport slave (
    input  enq_valid_i, enq_func_i, enq_mod_i, enq_half_i,
           enq_rs1_ready_i, enq_rs2_ready_i, enq_rs1_tag_i, enq_rs2_tag_i,
           enq_rs1_data_i, enq_rs2_data_i, enq_rd_i, enq_rob_i,
           wb_valid_i, wb_tag_i, wb_data_i, alu_ready_i,
    output enq_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_func_o,
           issue_mod_o, issue_half_o, issue_rd_o, issue_rob_o, count_o
  );

  modport master (
    output enq_valid_i, enq_func_i, enq_mod_i, enq_half_i,
           enq_rs1_ready_i, enq_rs2_ready_i, enq_rs1_tag_i, enq_rs2_tag_i,
           enq_rs1_data_i, enq_rs2_data_i, enq_rd_i, enq_rob_i,
           wb_valid_i, wb_tag_i, wb_data_i, alu_ready_i,
    input  enq_ready_o, issue_valid_o, issue_a_o, issue_b_o, issue_func_o,
           issue_mod_o, issue_half_o, issue_rd_o, issue_rob_o, count_o
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Age-ordered collapsing reservation station feeding the two-stage ALU through
// a registered issue slot; operands are captured from the writeback wakeup bus.
module alu_issue_scheduler #(
  parameter int DEPTH              = 4,
  parameter int XLEN               = 64,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int ROB_INDEX_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  alu_issue_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]                    func;
    logic                          mod;
    logic                          half;
    logic                          rs1_rdy;
    logic                          rs2_rdy;
    logic [PHY_REG_ADDR_WIDTH-1:0] rs1_tag;
    logic [PHY_REG_ADDR_WIDTH-1:0] rs2_tag;
    logic [XLEN-1:0]               rs1_data;
    logic [XLEN-1:0]               rs2_data;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
  } entry_t;

  entry_t                        ent_r   [DEPTH];
  entry_t                        woke_s  [DEPTH];
  entry_t                        nxt_s   [DEPTH];
  entry_t                        enq_ent_s;
  logic [CW-1:0]                 count_r;
  logic [CW-1:0]                 count_nxt_s;
  logic                          slot_free_s;
  logic                          found_s;
  logic                          deq_s;
  logic                          enq_fire_s;
  logic [IW-1:0]                 sel_idx_s;
  logic [IW-1:0]                 enq_idx_s;

  logic                          issue_valid_r;
  logic [XLEN-1:0]               issue_a_r;
  logic [XLEN-1:0]               issue_b_r;
  logic [2:0]                    issue_func_r;
  logic                          issue_mod_r;
  logic                          issue_half_r;
  logic [PHY_REG_ADDR_WIDTH-1:0] issue_rd_r;
  logic [ROB_INDEX_WIDTH-1:0]    issue_rob_r;

  // Handshake qualifiers; enqueue readiness looks only at the registered count.
  always_comb begin
    slot_free_s = !issue_valid_r || bus.alu_ready_i;
    deq_s       = slot_free_s && found_s;
    enq_fire_s  = bus.enq_valid_i && (count_r < CW'(DEPTH));
    enq_idx_s   = IW'(count_r - CW'(deq_s));
    count_nxt_s = count_r + CW'(enq_fire_s) - CW'(deq_s);
  end

  // Oldest valid entry with both operands ready; scanned young-to-old so the lowest index wins.
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((i < int'(count_r)) && ent_r[i].rs1_rdy && ent_r[i].rs2_rdy) begin
        found_s   = 1'b1;
        sel_idx_s = IW'(i);
      end else begin
      end
    end
  end

  // Incoming op, picking up a same-cycle broadcast for any source not yet ready.
  always_comb begin
    enq_ent_s.func     = bus.enq_func_i;
    enq_ent_s.mod      = bus.enq_mod_i;
    enq_ent_s.half     = bus.enq_half_i;
    enq_ent_s.rs1_tag  = bus.enq_rs1_tag_i;
    enq_ent_s.rs2_tag  = bus.enq_rs2_tag_i;
    enq_ent_s.rd       = bus.enq_rd_i;
    enq_ent_s.rob      = bus.enq_rob_i;
    enq_ent_s.rs1_rdy  = bus.enq_rs1_ready_i;
    enq_ent_s.rs1_data = bus.enq_rs1_data_i;
    enq_ent_s.rs2_rdy  = bus.enq_rs2_ready_i;
    enq_ent_s.rs2_data = bus.enq_rs2_data_i;
    if (!bus.enq_rs1_ready_i && bus.wb_valid_i && (bus.wb_tag_i == bus.enq_rs1_tag_i)) begin
      enq_ent_s.rs1_rdy  = 1'b1;
      enq_ent_s.rs1_data = bus.wb_data_i;
    end else begin
    end
    if (!bus.enq_rs2_ready_i && bus.wb_valid_i && (bus.wb_tag_i == bus.enq_rs2_tag_i)) begin
      enq_ent_s.rs2_rdy  = 1'b1;
      enq_ent_s.rs2_data = bus.wb_data_i;
    end else begin
    end
  end

  // Next queue image: wakeup, then collapse over the removed entry, then append behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke_s[i] = ent_r[i];
      if (bus.wb_valid_i && !ent_r[i].rs1_rdy && (ent_r[i].rs1_tag == bus.wb_tag_i)) begin
        woke_s[i].rs1_rdy  = 1'b1;
        woke_s[i].rs1_data = bus.wb_data_i;
      end else begin
      end
      if (bus.wb_valid_i && !ent_r[i].rs2_rdy && (ent_r[i].rs2_tag == bus.wb_tag_i)) begin
        woke_s[i].rs2_rdy  = 1'b1;
        woke_s[i].rs2_data = bus.wb_data_i;
      end else begin
      end
    end
    // The top slot wraps to entry 0 on a collapse; it lies beyond the new count and is never read.
    for (int i = 0; i < DEPTH; i++) begin
      if (deq_s && (i >= int'(sel_idx_s))) begin
        nxt_s[i] = woke_s[(i + 1) % DEPTH];
      end else begin
        nxt_s[i] = woke_s[i];
      end
    end
    if (enq_fire_s) begin
      nxt_s[enq_idx_s] = enq_ent_s;
    end else begin
    end
  end

  // Queue contents, occupancy and the issue slot; reset and flush clear everything.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      count_r       <= '0;
      issue_valid_r <= 1'b0;
      issue_a_r     <= '0;
      issue_b_r     <= '0;
      issue_func_r  <= 3'b000;
      issue_mod_r   <= 1'b0;
      issue_half_r  <= 1'b0;
      issue_rd_r    <= '0;
      issue_rob_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= nxt_s[i];
      end
      if (slot_free_s) begin
        issue_valid_r <= found_s;
        if (found_s) begin
          issue_a_r    <= ent_r[sel_idx_s].rs1_data;
          issue_b_r    <= ent_r[sel_idx_s].rs2_data;
          issue_func_r <= ent_r[sel_idx_s].func;
          issue_mod_r  <= ent_r[sel_idx_s].mod;
          issue_half_r <= ent_r[sel_idx_s].half;
          issue_rd_r   <= ent_r[sel_idx_s].rd;
          issue_rob_r  <= ent_r[sel_idx_s].rob;
        end else begin
        end
      end else begin
      end
    end
  end

  assign bus.enq_ready_o   = (count_r < CW'(DEPTH));
  assign bus.count_o       = count_r;
  assign bus.issue_valid_o = issue_valid_r;
  assign bus.issue_a_o     = issue_a_r;
  assign bus.issue_b_o     = issue_b_r;
  assign bus.issue_func_o  = issue_func_r;
  assign bus.issue_mod_o   = issue_mod_r;
  assign bus.issue_half_o  = issue_half_r;
  assign bus.issue_rd_o    = issue_rd_r;
  assign bus.issue_rob_o   = issue_rob_r;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: directed scenarios plus random traffic,
// checked against a queue-level reference model of the reservation station.
module tb_alu_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int PW    = 6;
  localparam int RW    = 4;

  typedef struct {
    logic [2:0]      func;
    logic            md;
    logic            hf;
    logic            r1;
    logic            r2;
    logic [PW-1:0]   t1;
    logic [PW-1:0]   t2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [PW-1:0]   rd;
    logic [RW-1:0]   rob;
  } op_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.DEPTH(DEPTH), .XLEN(XLEN), .PHY_REG_ADDR_WIDTH(PW), .ROB_INDEX_WIDTH(RW)) bus ();

  alu_issue_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN), .PHY_REG_ADDR_WIDTH(PW), .ROB_INDEX_WIDTH(RW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush),
    .bus  (bus)
  );

  int  checks = 0;
  int  errors = 0;
  op_t mq[$];
  op_t exq[$];
  op_t mslot;
  bit  mslot_v = 1'b0;
  op_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock edge, using the inputs present at that edge.
  task automatic model_step();
    int  osz;
    int  ci;
    op_t e;
    if (!rstn) begin
      mq.delete();
      exq.delete();
      mslot_v = 1'b0;
    end else if (flush) begin
      if (mslot_v && !bus.alu_ready_i) void'(exq.pop_back());
      mq.delete();
      mslot_v = 1'b0;
    end else begin
      osz = mq.size();
      if (!mslot_v || bus.alu_ready_i) begin
        ci = -1;
        foreach (mq[i]) if (ci < 0 && mq[i].r1 && mq[i].r2) ci = i;
        if (ci >= 0) begin
          mslot   = mq[ci];
          mslot_v = 1'b1;
          mq.delete(ci);
          exq.push_back(mslot);
        end else begin
          mslot_v = 1'b0;
        end
      end
      foreach (mq[i]) begin
        if (bus.wb_valid_i && !mq[i].r1 && mq[i].t1 == bus.wb_tag_i) begin mq[i].r1 = 1'b1; mq[i].d1 = bus.wb_data_i; end
        if (bus.wb_valid_i && !mq[i].r2 && mq[i].t2 == bus.wb_tag_i) begin mq[i].r2 = 1'b1; mq[i].d2 = bus.wb_data_i; end
      end
      if (bus.enq_valid_i && osz < DEPTH) begin
        e.func = bus.enq_func_i;   e.md = bus.enq_mod_i;    e.hf = bus.enq_half_i;
        e.r1 = bus.enq_rs1_ready_i; e.t1 = bus.enq_rs1_tag_i; e.d1 = bus.enq_rs1_data_i;
        e.r2 = bus.enq_rs2_ready_i; e.t2 = bus.enq_rs2_tag_i; e.d2 = bus.enq_rs2_data_i;
        e.rd = bus.enq_rd_i;       e.rob = bus.enq_rob_i;
        if (!e.r1 && bus.wb_valid_i && e.t1 == bus.wb_tag_i) begin e.r1 = 1'b1; e.d1 = bus.wb_data_i; end
        if (!e.r2 && bus.wb_valid_i && e.t2 == bus.wb_tag_i) begin e.r2 = 1'b1; e.d2 = bus.wb_data_i; end
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic enq(input logic [2:0] f, input logic md, input logic hf,
                     input logic r1, input logic [PW-1:0] t1, input logic [XLEN-1:0] d1,
                     input logic r2, input logic [PW-1:0] t2, input logic [XLEN-1:0] d2,
                     input logic [PW-1:0] rd, input logic [RW-1:0] rob);
    bus.enq_valid_i = 1'b1;  bus.enq_func_i = f;  bus.enq_mod_i = md;  bus.enq_half_i = hf;
    bus.enq_rs1_ready_i = r1; bus.enq_rs1_tag_i = t1; bus.enq_rs1_data_i = d1;
    bus.enq_rs2_ready_i = r2; bus.enq_rs2_tag_i = t2; bus.enq_rs2_data_i = d2;
    bus.enq_rd_i = rd;        bus.enq_rob_i = rob;
  endtask

  // Monitor: occupancy/slot state every cycle, scoreboard pop on every ALU transfer.
  always @(negedge clk) begin
    if (rstn) begin
      chk("issue_valid", bus.issue_valid_o, mslot_v);
      chk("count", bus.count_o, mq.size());
      chk("enq_ready", bus.enq_ready_o, mq.size() < DEPTH);
      if (bus.issue_valid_o && mslot_v) begin
        chk("slot_a", bus.issue_a_o, mslot.d1);
        chk("slot_rob", bus.issue_rob_o, mslot.rob);
      end
      if (bus.issue_valid_o && bus.alu_ready_i) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer: transfer with no expected op at %0t", $time);
        end else begin
          mon_e = exq.pop_front();
          chk("xfer_a", bus.issue_a_o, mon_e.d1);
          chk("xfer_b", bus.issue_b_o, mon_e.d2);
          chk("xfer_func", bus.issue_func_o, mon_e.func);
          chk("xfer_mod", bus.issue_mod_o, mon_e.md);
          chk("xfer_half", bus.issue_half_o, mon_e.hf);
          chk("xfer_rd", bus.issue_rd_o, mon_e.rd);
          chk("xfer_rob", bus.issue_rob_o, mon_e.rob);
        end
      end
    end
  end

  initial begin
    bus.wb_valid_i = 1'b0; bus.wb_tag_i = '0; bus.wb_data_i = '0;
    bus.alu_ready_i = 1'b1;
    enq(3'd0, 1'b0, 1'b0, 1'b1, 6'd1, 64'd1, 1'b1, 6'd2, 64'd2, 6'd3, 4'd4);

    // Reset held two cycles with a pending enqueue
    tick(); tick();
    rstn = 1'b1;
    bus.enq_valid_i = 1'b0;
    chk("rst_valid", bus.issue_valid_o, 1'b0);
    chk("rst_count", bus.count_o, 64'd0);
    chk("rst_enq_ready", bus.enq_ready_o, 1'b1);
    chk("rst_a", bus.issue_a_o, 64'd0);

    // Ready ADD: valid two edges after the enqueue edge
    enq(3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd7, 6'd9, 4'd3);
    tick();
    bus.enq_valid_i = 1'b0;
    chk("ready_n1_valid", bus.issue_valid_o, 1'b0);
    chk("ready_n1_count", bus.count_o, 64'd1);
    tick();
    chk("ready_valid", bus.issue_valid_o, 1'b1);
    chk("ready_a", bus.issue_a_o, 64'd5);
    chk("ready_b", bus.issue_b_o, 64'd7);
    chk("ready_func", bus.issue_func_o, 64'd0);
    chk("ready_rd", bus.issue_rd_o, 64'd9);
    chk("ready_rob", bus.issue_rob_o, 64'd3);
    chk("ready_count", bus.count_o, 64'd0);
    tick();

    // Age order with a waiting older op, then wakeup
    enq(3'd1, 1'b1, 1'b0, 1'b0, 6'd12, 64'd0, 1'b1, 6'd0, 64'h1, 6'd20, 4'd6);
    tick();
    enq(3'd2, 1'b0, 1'b1, 1'b1, 6'd0, 64'h11, 1'b1, 6'd0, 64'h22, 6'd2, 4'd5);
    tick();
    bus.enq_valid_i = 1'b0;
    tick();
    chk("age_young_first", bus.issue_rob_o, 64'd5);
    tick();
    bus.wb_valid_i = 1'b1; bus.wb_tag_i = 6'd12; bus.wb_data_i = 64'h100;
    tick();
    bus.wb_valid_i = 1'b0;
    chk("wake_not_yet", bus.issue_valid_o, 1'b0);
    tick();
    chk("wake_valid", bus.issue_valid_o, 1'b1);
    chk("wake_a", bus.issue_a_o, 64'h100);
    chk("wake_rob", bus.issue_rob_o, 64'd6);
    tick();

    // Enqueue bypass from the same-cycle broadcast
    enq(3'd3, 1'b0, 1'b0, 1'b1, 6'd0, 64'h3, 1'b0, 6'd7, 64'h0, 6'd8, 4'd9);
    bus.wb_valid_i = 1'b1; bus.wb_tag_i = 6'd7; bus.wb_data_i = 64'hAB;
    tick();
    bus.enq_valid_i = 1'b0; bus.wb_valid_i = 1'b0;
    tick();
    chk("bypass_valid", bus.issue_valid_o, 1'b1);
    chk("bypass_b", bus.issue_b_o, 64'hAB);
    tick();

    // Full with the ALU stalled; a sixth enqueue is refused
    bus.alu_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      enq(3'd4, 1'b0, 1'b0, 1'b1, 6'd0, 64'h40 + 64'(k), 1'b1, 6'd0, 64'h80 + 64'(k), 6'(k), 4'(k));
      tick();
    end
    bus.enq_valid_i = 1'b0;
    tick();
    chk("full_count", bus.count_o, 64'd4);
    chk("full_enq_ready", bus.enq_ready_o, 1'b0);
    chk("full_slot_a", bus.issue_a_o, 64'h40);
    tick();
    chk("stall_hold_a", bus.issue_a_o, 64'h40);
    bus.alu_ready_i = 1'b1;
    tick();
    chk("drain_second", bus.issue_a_o, 64'h41);
    for (int k = 0; k < 5; k++) tick();

    // Flush with a held slot, three queued ops and an enqueue in the flush cycle
    bus.alu_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq(3'd5, 1'b0, 1'b0, 1'b1, 6'd0, 64'h200 + 64'(k), 1'b1, 6'd0, 64'h0, 6'd1, 4'(k));
      tick();
    end
    bus.enq_valid_i = 1'b0;
    tick();
    chk("preflush_count", bus.count_o, 64'd3);
    flush = 1'b1;
    enq(3'd6, 1'b0, 1'b0, 1'b1, 6'd0, 64'h999, 1'b1, 6'd0, 64'h0, 6'd1, 4'd1);
    tick();
    flush = 1'b0;
    bus.enq_valid_i = 1'b0;
    chk("flush_count", bus.count_o, 64'd0);
    chk("flush_valid", bus.issue_valid_o, 1'b0);
    bus.alu_ready_i = 1'b1;
    tick(); tick();
    chk("flush_enq_dropped", bus.count_o, 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      enq(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 99) < 60), 6'($urandom_range(0, 15)), {$urandom, $urandom},
          1'($urandom_range(0, 99) < 60), 6'($urandom_range(0, 15)), {$urandom, $urandom},
          6'($urandom), 4'($urandom));
      bus.enq_valid_i = ($urandom_range(0, 99) < 60);
      bus.wb_valid_i  = ($urandom_range(0, 99) < 50);
      bus.wb_tag_i    = 6'($urandom_range(0, 15));
      bus.wb_data_i   = {$urandom, $urandom};
      bus.alu_ready_i = ($urandom_range(0, 99) < 75);
      flush           = ($urandom_range(0, 99) < 2);
      tick();
    end
    flush = 1'b0;
    bus.enq_valid_i = 1'b0;
    bus.alu_ready_i = 1'b1;

    // Drain: broadcast every tag so waiting ops wake and issue
    for (int c = 0; c < 48; c++) begin
      bus.wb_valid_i = 1'b1;
      bus.wb_tag_i   = 6'(c % 16);
      bus.wb_data_i  = {$urandom, $urandom};
      tick();
    end
    bus.wb_valid_i = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("end_count", bus.count_o, 64'd0);
    chk("end_scoreboard_empty", 64'(exq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Small age-ordered reservation station that sequences operations into the single-issue two-stage integer ALU.
- Accepts renamed ALU ops from dispatch and captures source operands from the writeback wakeup bus.
- Selects the oldest op whose operands are both ready and drives the ALU inputs through a registered issue slot with a valid/ready handshake.
- Sits between dispatch/rename and the ALU; the ALU's ready output connects to alu_ready_i.

Parameters:
DEPTH, 4, number of queue entries (2..8)
XLEN, 64, operand width
PHY_REG_ADDR_WIDTH, 6, physical register tag width
ROB_INDEX_WIDTH, 4, ROB index width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  pipeline flush, synchronous clear
enq_valid_i  in  1  dispatch presents an op
enq_ready_o  out  1  queue can accept (count < DEPTH)
enq_func_i  in  3  ALU function select
enq_mod_i  in  1  function modifier (sub/sra/clr)
enq_half_i  in  1  32-bit (W) op
enq_rs1_ready_i / enq_rs2_ready_i  in  1 each  operand already valid
enq_rs1_tag_i / enq_rs2_tag_i  in  PHY_REG_ADDR_WIDTH each  source tags
enq_rs1_data_i / enq_rs2_data_i  in  XLEN each  operand values (used if ready)
enq_rd_i  in  PHY_REG_ADDR_WIDTH  destination tag
enq_rob_i  in  ROB_INDEX_WIDTH  ROB index
wb_valid_i  in  1  wakeup broadcast valid
wb_tag_i  in  PHY_REG_ADDR_WIDTH  produced tag
wb_data_i  in  XLEN  produced value
alu_ready_i  in  1  ALU accepts (not stalled)
issue_valid_o  out  1  issue slot holds an op
issue_a_o / issue_b_o  out  XLEN each  operands
issue_func_o / issue_mod_o / issue_half_o  out  3/1/1  decoded controls
issue_rd_o / issue_rob_o  out  PHY/ROB widths  destination tag, ROB index
count_o  out  $clog2(DEPTH+1)  occupied entries (excludes issue slot)

Behaviour:
- Reset (rstn=0 at a clk edge) and flush both clear all entry valids, count_o=0, and issue_valid_o=0. All issue data outputs reset to 0. Reset has priority over everything. An enqueue in a flush cycle is dropped.
- Queue is collapsing: entry 0 is oldest. Removing an entry shifts younger entries down by one in the same edge. An enqueue is written at index (count minus removed).
- Enqueue handshake: enq_valid_i & enq_ready_o. enq_ready_o = (count_o < DEPTH), registered state only; no credit for a same-cycle dequeue.
- Enqueue bypass: if wb_valid_i and wb_tag_i matches a non-ready source tag in the same cycle, that operand is stored ready with wb_data_i.
- Wakeup: each cycle, every valid entry's non-ready operand whose tag equals wb_tag_i (with wb_valid_i) captures wb_data_i and becomes ready at the edge.
- Select uses registered readiness only. An entry woken at edge E is selectable in the cycle after E.
- Select: the lowest-index valid entry with both operands ready. Select is enabled when the issue slot is free: issue_valid_o=0, or issue_valid_o & alu_ready_i in this cycle.
- When enabled and a candidate exists, at the edge the candidate loads the issue slot (issue_valid_o=1) and is removed from the queue.
- When enabled and there is no candidate, issue_valid_o goes to 0 at the edge.
- Issue handshake: a transfer occurs when issue_valid_o & alu_ready_i. While alu_ready_i=0, all issue outputs hold stable.
- Latency: an op enqueued with both operands ready at edge N is selected in cycle N+1, and issue_valid_o=1 from N+2. Sustained throughput is 1 op/cycle when alu_ready_i=1.
- Simultaneous enqueue + select + full: count_o stays DEPTH-1+1-1 as computed. The enqueue lands after the collapse. Counter never exceeds DEPTH and never underflows.
- W ops (enq_half_i=1) pass through unchanged; no width logic is applied here.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with enq_valid_i=1 -> issue_valid_o=0, count_o=0, enq_ready_o=1 after release.
- Ready op: enqueue ADD a=5, b=7, rd=9, rob=3 at edge N, alu_ready_i=1 -> issue_valid_o=1 at N+2 with a=5, b=7, func=ADD, rd=9, rob=3; count_o returns to 0.
- Age order + wakeup: enqueue op0 waiting on tag 12, then op1 ready -> op1 issues first. Broadcast tag 12 data 0x100 -> op0 issues two cycles later with a=0x100.
- Enqueue bypass: enqueue an op with rs2 tag 7 not ready while wb_tag_i=7, data 0xAB in the same cycle -> op issues at N+2 with b=0xAB.
- Full/stall: alu_ready_i=0, enqueue 5 ready ops -> 1 in issue slot, count_o=4, enq_ready_o=0, outputs stable. Raise alu_ready_i -> ops issue in enqueue order, one per cycle.
- Flush: 3 entries queued plus a held issue slot, assert flush with enq_valid_i=1 -> next cycle count_o=0, issue_valid_o=0, enqueued op absent.
